// File: rtl/fpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpc_pkg
// Description : Shared field widths, bias, status codes and converter states
//               for the custom 32-bit float datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fpc_pkg;

    localparam int EXP_W   = 6;
    localparam int FRAC_W  = 25;
    localparam int BIAS    = 31;
    localparam int SHIFT_W = 5;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [3:0] {
        FPC_EXACT     = 4'd0,
        FPC_OVERFLOW  = 4'd1,
        FPC_UNDERFLOW = 4'd2,
        FPC_INEXACT   = 4'd3
    } fpc_status_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNPACK = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_SIGN   = 2'd3
    } fpc_state_t;

endpackage
`default_nettype wire

// File: rtl/fpc_fields.sv
`default_nettype none
// ============================================================================
// Module      : fpc_fields
// Description : Splits a custom-float word into sign, exponent and the
//               significand with its hidden leading one restored.
// Revision    : 1.0 - initial release
// ============================================================================
module fpc_fields
    import fpc_pkg::*;
(
    input  logic [31:0]       i_word,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [FRAC_W:0]   o_sig
);

    assign o_sign = i_word[31];
    assign o_exp  = i_word[FRAC_W+EXP_W-1:FRAC_W];
    assign o_sig  = {1'b1, i_word[FRAC_W-1:0]};

endmodule
`default_nettype wire

// File: rtl/fpc_to_int.sv
`default_nettype none
// ============================================================================
// Module      : fpc_to_int
// Description : Custom float to 32-bit signed integer, truncating toward zero,
//               using a one-bit-per-cycle shifter with start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fpc_to_int #(
    parameter int BIAS = fpc_pkg::BIAS
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] int_out,
    output logic [3:0]  status_out
);
    import fpc_pkg::*;

    fpc_state_t          r_state, w_state_nxt;
    logic                r_sign, r_frac_zero, r_left, r_sticky, r_special, r_sat;
    logic [EXP_W-1:0]    r_exp;
    logic [31:0]         r_mag;
    logic [SHIFT_W-1:0]  r_cnt;
    fpc_status_t         r_spec_status;

    logic                w_sign;
    logic [EXP_W-1:0]    w_exp;
    logic [FRAC_W:0]     w_sig;
    logic signed [6:0]   w_e;
    logic                w_special, w_sat, w_left;
    logic [SHIFT_W-1:0]  w_cnt;
    fpc_status_t         w_spec_status, w_status;
    logic [31:0]         w_int;

    fpc_fields u_fields (
        .i_word (data_in),
        .o_sign (w_sign),
        .o_exp  (w_exp),
        .o_sig  (w_sig)
    );

    assign w_e = {1'b0, r_exp} - 7'(BIAS);

    // Classification order matters: e==0 and e==63 win over the E range tests.
    always_comb begin
        w_special     = 1'b0;
        w_sat         = 1'b0;
        w_left        = 1'b0;
        w_cnt         = '0;
        w_spec_status = FPC_EXACT;
        if (r_exp == '0) begin
            w_special     = 1'b1;
            w_spec_status = FPC_UNDERFLOW;
        end else if (r_exp == '1) begin
            w_special     = 1'b1;
            w_sat         = 1'b1;
            w_spec_status = FPC_OVERFLOW;
        end else if (w_e >= 7'sd31) begin
            w_special     = 1'b1;
            w_sat         = 1'b1;
            w_spec_status = (r_sign && w_e == 7'sd31 && r_frac_zero) ? FPC_EXACT : FPC_OVERFLOW;
        end else if (w_e < 7'sd0) begin
            w_special     = 1'b1;
            w_spec_status = FPC_INEXACT;
        end else if (w_e <= 7'sd25) begin
            w_cnt = 5'd25 - w_e[4:0];
        end else begin
            w_left = 1'b1;
            w_cnt  = w_e[4:0] - 5'd25;
        end
    end

    always_comb begin
        w_int    = r_sign ? (~r_mag + 32'd1) : r_mag;
        w_status = r_sticky ? FPC_INEXACT : FPC_EXACT;
        if (r_special) begin
            w_int    = r_sat ? (r_sign ? INT_MIN : INT_MAX) : 32'd0;
            w_status = r_spec_status;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_UNPACK;
            ST_UNPACK: w_state_nxt = (w_special || w_cnt == '0) ? ST_SIGN : ST_SHIFT;
            ST_SHIFT:  if (r_cnt == 5'd1) w_state_nxt = ST_SIGN;
            ST_SIGN:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock_100kHz) begin
        if (reset) begin
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_frac_zero   <= 1'b0;
            r_mag         <= '0;
            r_cnt         <= '0;
            r_left        <= 1'b0;
            r_sticky      <= 1'b0;
            r_special     <= 1'b0;
            r_sat         <= 1'b0;
            r_spec_status <= FPC_EXACT;
            busy          <= 1'b0;
            done          <= 1'b0;
            int_out       <= '0;
            status_out    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign      <= w_sign;
                        r_exp       <= w_exp;
                        r_frac_zero <= (w_sig[FRAC_W-1:0] == '0);
                        r_mag       <= {{(32-FRAC_W-1){1'b0}}, w_sig};
                        r_sticky    <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_UNPACK: begin
                    r_special     <= w_special;
                    r_sat         <= w_sat;
                    r_spec_status <= w_spec_status;
                    r_left        <= w_left;
                    r_cnt         <= w_cnt;
                end
                ST_SHIFT: begin
                    if (r_left) begin
                        r_mag <= r_mag << 1;
                    end else begin
                        r_mag    <= r_mag >> 1;
                        r_sticky <= r_sticky | r_mag[0];
                    end
                    r_cnt <= r_cnt - 5'd1;
                end
                ST_SIGN: begin
                    int_out    <= w_int;
                    status_out <= w_status;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpc_to_int.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpc_to_int
// Description : Scoreboard bench for fpc_to_int: expected results queued at
//               start, popped and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpc_to_int;

    logic        clock_100kHz = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        busy, done;
    logic [31:0] int_out;
    logic [3:0]  status_out;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] i;
        logic [3:0]  st;
        int          edges;
    } exp_t;

    exp_t sb[$];

    fpc_to_int #(.BIAS(31)) dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .busy         (busy),
        .done         (done),
        .int_out      (int_out),
        .status_out   (status_out)
    );

    always #5 clock_100kHz = ~clock_100kHz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    // Reference conversion: value = (-1)^s * 1.f * 2^(e-31), truncated.
    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        int          ex, sh;
        logic [31:0] m, r;
        ex      = int'(w[30:25]) - 31;
        m       = {6'b0, 1'b1, w[24:0]};
        e.edges = 3;
        if (w[30:25] == 6'd0) begin
            e.i = 32'd0; e.st = 4'd2;
        end else if (w[30:25] == 6'd63 || ex >= 31) begin
            e.i  = w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            e.st = (w[31] && ex == 31 && w[24:0] == 25'd0 && w[30:25] != 6'd63) ? 4'd0 : 4'd1;
        end else if (ex < 0) begin
            e.i = 32'd0; e.st = 4'd3;
        end else if (ex <= 25) begin
            sh      = 25 - ex;
            r       = m >> sh;
            e.st    = ((m & ((32'd1 << sh) - 32'd1)) != 32'd0) ? 4'd3 : 4'd0;
            e.i     = w[31] ? (32'd0 - r) : r;
            e.edges = 3 + sh;
        end else begin
            sh      = ex - 25;
            r       = m << sh;
            e.st    = 4'd0;
            e.i     = w[31] ? (32'd0 - r) : r;
            e.edges = 3 + sh;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] w, input exp_t e);
        @(negedge clock_100kHz);
        data_in = w;
        start   = 1'b1;
        sb.push_back(e);
        @(posedge clock_100kHz);
        #1;
        start   = 1'b0;
        data_in = ~w;
    endtask

    // Returns the edge count from the accepting edge (counted as 1) to done.
    task automatic wait_done(output int edges, output bit ok);
        edges = 1;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock_100kHz);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock_100kHz);
        #1;
        n_checks++;
        if ({busy, done, int_out, status_out} !== 38'd0)
            $display("FAIL reset_state: got busy=%b done=%b int=%h st=%0d, want all 0",
                     busy, done, int_out, status_out);
        else n_pass++;
        @(negedge clock_100kHz);
        reset = 1'b0;
    endtask

    task automatic test_plan();
        logic [31:0] words [13];
        logic [31:0] ints  [13];
        logic [3:0]  sts   [13];
        int          lat   [13];
        exp_t        e, got_e;
        int          edges;
        bit          ok;
        words = '{32'h4280_0000, 32'hC080_0000, 32'h3C00_0000, 32'h0000_0000, 32'h7A00_0000,
                  32'h7C00_0000, 32'hFC00_0000, 32'h7E00_0000, 32'h3E00_0000, 32'hFE00_0000,
                  32'hFC00_0001, 32'h4000_0000, 32'h8000_0000};
        ints  = '{32'd5, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'h4000_0000,
                  32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000,
                  32'h8000_0000, 32'd2, 32'd0};
        sts   = '{4'd0, 4'd3, 4'd3, 4'd2, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd2};
        lat   = '{26, 27, 3, 3, 8, 3, 3, 3, 28, 3, 3, 27, 3};
        for (int t = 0; t < 13; t++) begin
            e.i = ints[t]; e.st = sts[t]; e.edges = lat[t];
            issue(words[t], e);
            n_checks++;
            if (busy !== 1'b1) $display("FAIL plan_busy[%h]: got %b, want 1", words[t], busy);
            else n_pass++;
            wait_done(edges, ok);
            got_e = sb.pop_front();
            n_checks++;
            if (!ok)
                $display("FAIL plan_timeout[%h]: got no done, want done", words[t]);
            else if (int_out !== got_e.i || status_out !== got_e.st || edges != got_e.edges)
                $display("FAIL plan[%h]: got int=%h st=%0d edges=%0d, want int=%h st=%0d edges=%0d",
                         words[t], int_out, status_out, edges, got_e.i, got_e.st, got_e.edges);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        exp_t        got_e;
        int          edges;
        bit          ok;
        for (int t = 0; t < 24; t++) begin
            w = $urandom;
            if (t % 2 == 1) w[30:25] = 6'($urandom_range(31, 62));
            issue(w, model(w));
            wait_done(edges, ok);
            got_e = sb.pop_front();
            n_checks++;
            if (!ok)
                $display("FAIL rand_timeout[%h]: got no done, want done", w);
            else if (int_out !== got_e.i || status_out !== got_e.st || edges != got_e.edges)
                $display("FAIL rand[%h]: got int=%h st=%0d edges=%0d, want int=%h st=%0d edges=%0d",
                         w, int_out, status_out, edges, got_e.i, got_e.st, got_e.edges);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t a, b, got_e;
        int   edges;
        bit   ok;
        a = model(32'h4280_0000);
        b = model(32'hC080_0000);
        issue(32'h4280_0000, a);
        wait_done(edges, ok);
        got_e = sb.pop_front();
        n_checks++;
        if (!ok || int_out !== got_e.i || status_out !== got_e.st)
            $display("FAIL b2b_first: got ok=%b int=%h st=%0d, want int=%h st=%0d",
                     ok, int_out, status_out, got_e.i, got_e.st);
        else n_pass++;
        // Start asserted in the done cycle must be accepted.
        data_in = 32'hC080_0000;
        start   = 1'b1;
        sb.push_back(b);
        @(posedge clock_100kHz);
        #1;
        start   = 1'b0;
        data_in = 32'h7C00_0000;
        n_checks++;
        if (busy !== 1'b1 || int_out !== a.i || done !== 1'b0)
            $display("FAIL b2b_accept_hold: got busy=%b done=%b int=%h, want busy=1 done=0 int=%h",
                     busy, done, int_out, a.i);
        else n_pass++;
        wait_done(edges, ok);
        got_e = sb.pop_front();
        n_checks++;
        if (!ok || int_out !== got_e.i || status_out !== got_e.st || edges != got_e.edges)
            $display("FAIL b2b_second: got int=%h st=%0d edges=%0d, want int=%h st=%0d edges=%0d",
                     int_out, status_out, edges, got_e.i, got_e.st, got_e.edges);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        exp_t got_e;
        int   edges;
        bit   ok;
        bit   extra;
        issue(32'h4280_0000, model(32'h4280_0000));
        fork
            begin
                for (int p = 0; p < 10; p++) begin
                    @(negedge clock_100kHz);
                    start   = p[0];
                    data_in = 32'h7C00_0000;
                end
                @(negedge clock_100kHz);
                start = 1'b0;
            end
            wait_done(edges, ok);
        join
        got_e = sb.pop_front();
        n_checks++;
        if (!ok || int_out !== got_e.i || status_out !== got_e.st || edges != got_e.edges)
            $display("FAIL busy_ignore: got int=%h st=%0d edges=%0d, want int=%h st=%0d edges=%0d",
                     int_out, status_out, edges, got_e.i, got_e.st, got_e.edges);
        else n_pass++;
        extra = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clock_100kHz);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) extra = 1'b1;
        end
        n_checks++;
        if (extra) $display("FAIL busy_ignore_idle: got extra activity=1, want 0");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t got_e;
        int   edges;
        bit   ok;
        issue(32'h4280_0000, model(32'h4280_0000));
        repeat (5) @(posedge clock_100kHz);
        @(negedge clock_100kHz);
        reset = 1'b1;
        @(posedge clock_100kHz);
        #1;
        got_e = sb.pop_front();
        n_checks++;
        if ({busy, done, int_out, status_out} !== 38'd0)
            $display("FAIL reset_mid: got busy=%b done=%b int=%h st=%0d, want all 0",
                     busy, done, int_out, status_out);
        else n_pass++;
        @(negedge clock_100kHz);
        reset = 1'b0;
        issue(32'h4280_0000, model(32'h4280_0000));
        wait_done(edges, ok);
        got_e = sb.pop_front();
        n_checks++;
        if (!ok || int_out !== 32'd5 || status_out !== 4'd0 || edges != got_e.edges)
            $display("FAIL reset_mid_restart: got int=%h st=%0d edges=%0d, want int=5 st=0 edges=%0d",
                     int_out, status_out, edges, got_e.edges);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_plan();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
